// File: rtl/ks_adder_pipe_if.sv
// ks_adder_pipe_if: operand/result handshake bundle for ks_adder_pipe.
//   in_valid/in_ready   : operand handshake (a, b, ci, sub)
//   out_valid/out_ready : result handshake (sum, co[, ovf])
//   ovf exists only when KS_ADDER_PIPE_OVF_EN is defined.
// Modports: master = operand producer / result consumer, slave = the adder.
interface ks_adder_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
`ifdef KS_ADDER_PIPE_OVF_EN
  logic             ovf;
`endif

  modport master (
`ifdef KS_ADDER_PIPE_OVF_EN
    input  ovf,
`endif
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, sum, co
  );

  modport slave (
`ifdef KS_ADDER_PIPE_OVF_EN
    output ovf,
`endif
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, sum, co
  );
endinterface

// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: pipelined Kogge-Stone adder/subtractor.
//   {co,sum} = a + (sub ? ~b : b) + (ci ^ sub)
// Stage 0 registers per-bit generate/propagate; one register stage follows
// each of the LEVELS = clog2(WIDTH) prefix levels, so latency is LEVELS+1.
// A single stall (head valid, consumer not ready) freezes every stage.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : ks_adder_pipe_if.slave (in_valid/in_ready/a/b/ci/sub,
//           out_valid/out_ready/sum/co)
// Optional: define KS_ADDER_PIPE_OVF_EN to add bus.ovf (signed overflow).
module ks_adder_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  ks_adder_pipe_if.slave  bus
);
  localparam int unsigned LEVELS = $clog2(WIDTH);
  localparam int unsigned LAT    = LEVELS + 1;

  logic [LAT-1:0]              vld;
  logic [LEVELS:0][WIDTH-1:0]  gq;  // group generate per stage
  logic [LEVELS-1:0][WIDTH-1:0] pq; // group propagate (not needed after last level)
  logic [LEVELS:0][WIDTH-1:0]  xq;  // original a ^ b_eff, needed for the sum
  logic [LEVELS:0]             cq;  // effective carry-in
  logic                        stall;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic             cin;

  // Carry-in is folded into bit 0 so the prefix tree sees it as a generate;
  // bit-0 propagate is then cleared because nothing lies below it.
  always_comb begin
    b_eff   = bus.sub ? ~bus.b : bus.b;
    cin     = bus.ci ^ bus.sub;
    p_in    = bus.a ^ b_eff;
    g_in    = bus.a & b_eff;
    g_in[0] = g_in[0] | (p_in[0] & cin);
  end

  assign stall         = vld[LAT-1] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = vld[LAT-1];

  // Carry into bit i is the final group generate of bit i-1 (cin for bit 0).
  assign bus.sum = xq[LEVELS] ^ {gq[LEVELS][WIDTH-2:0], cq[LEVELS]};
  assign bus.co  = gq[LEVELS][WIDTH-1];

`ifdef KS_ADDER_PIPE_OVF_EN
  assign bus.ovf = gq[LEVELS][WIDTH-1] ^ gq[LEVELS][WIDTH-2];
`endif

  // Level k combines with the partner 2^(k-1) bits below. Shifting in zeros
  // for generate and ones for propagate leaves the low bits without a
  // partner unchanged, which also handles non-power-of-two widths.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld        <= '0;
      gq[LEVELS] <= '0;
      xq[LEVELS] <= '0;
      cq[LEVELS] <= 1'b0;
    end else if (!stall) begin
      vld   <= {vld[LAT-2:0], bus.in_valid};
      gq[0] <= g_in;
      pq[0] <= {p_in[WIDTH-1:1], 1'b0};
      xq[0] <= p_in;
      cq[0] <= cin;
      for (int unsigned k = 1; k <= LEVELS; k++) begin
        gq[k] <= gq[k-1] | (pq[k-1] & (gq[k-1] << (32'd1 << (k - 1))));
        xq[k] <= xq[k-1];
        cq[k] <= cq[k-1];
      end
      for (int unsigned k = 1; k < LEVELS; k++) begin
        pq[k] <= pq[k-1] & ((pq[k-1] << (32'd1 << (k - 1)))
                            | ~({WIDTH{1'b1}} << (32'd1 << (k - 1))));
      end
    end
  end
endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb_ks_adder_pipe: directed and sweep checks of ks_adder_pipe at
// WIDTH=16 (LAT=5), WIDTH=5 (LAT=4) and WIDTH=64 (LAT=7).
module tb_ks_adder_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ks_adder_pipe_if #(.WIDTH(16)) bus16 ();
  ks_adder_pipe_if #(.WIDTH(5))  bus5 ();
  ks_adder_pipe_if #(.WIDTH(64)) bus64 ();

  ks_adder_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  ks_adder_pipe #(.WIDTH(5))  dut5  (.clk(clk), .rst_n(rst_n), .bus(bus5));
  ks_adder_pipe #(.WIDTH(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  // Arithmetic reference: {co,sum} in bits [w:0].
  function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic c, input logic s, input int unsigned w);
    logic [63:0] m;
    logic [63:0] ye;
    m  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    ye = (s ? ~y : y) & m;
    return {1'b0, x & m} + {1'b0, ye} + 65'(c ^ s);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus16.out_valid); end
    checks++; if (bus16.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus16.in_ready); end
    checks++; if (bus16.sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", bus16.sum); end
    checks++; if (bus16.co !== 1'b0) begin errors++; $display("FAIL reset_co: got %b expected 0", bus16.co); end
    checks++; if (bus5.out_valid !== 1'b0 || bus64.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_w5_w64: got %b/%b expected 0/0", bus5.out_valid, bus64.out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    bus16.in_valid = 1'b1; bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.ci = 1'b0; bus16.sub = 1'b0;
    @(negedge clk);
    checks++; if (bus16.in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready: got %b expected 1", bus16.in_ready); end
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus16.out_valid !== (n == 5)) begin errors++; $display("FAIL lat_out_valid cycle %0d: got %b expected %b", n, bus16.out_valid, (n == 5)); end
      if (n == 5) begin
        checks++; if (bus16.sum !== 16'h0000 || bus16.co !== 1'b1) begin errors++; $display("FAIL lat_result: got co=%b sum=%h expected co=1 sum=0000", bus16.co, bus16.sum); end
      end
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta [6];
    logic [15:0] tb [6];
    logic [15:0] es [6];
    logic        tc [6];
    logic        ts [6];
    logic        ec [6];
    int issued = 0, got = 0, cyc = 0;
    ta = '{16'h0005, 16'h0007, 16'h1234, 16'h8000, 16'h0000, 16'h0000};
    tb = '{16'h0007, 16'h0005, 16'h4321, 16'h8000, 16'h0000, 16'h0000};
    tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ts = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    es = '{16'hFFFE, 16'h0002, 16'h5556, 16'h0000, 16'h0001, 16'h0000};
    ec = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    while (got < 6 && cyc < 40) begin
      @(posedge clk); #1;
      if (issued < 6) begin
        bus16.in_valid = 1'b1; bus16.a = ta[issued]; bus16.b = tb[issued];
        bus16.ci = tc[issued]; bus16.sub = ts[issued];
      end else bus16.in_valid = 1'b0;
      @(negedge clk);
      if (bus16.in_valid && bus16.in_ready) issued++;
      if (bus16.out_valid && bus16.out_ready) begin
        checks++;
        if (bus16.sum !== es[got] || bus16.co !== ec[got]) begin
          errors++; $display("FAIL directed_%0d: got co=%b sum=%h expected co=%b sum=%h", got, bus16.co, bus16.sum, ec[got], es[got]);
        end
        got++;
      end
      cyc++;
    end
    bus16.in_valid = 1'b0;
    checks++; if (got != 6) begin errors++; $display("FAIL directed_count: got %0d results expected 6", got); end
  endtask

  task automatic test_back_to_back();
    logic [64:0] exq [$];
    logic [64:0] e;
    logic [15:0] opa [8];
    logic [15:0] opb [8];
    logic        opc [8];
    logic        ops [8];
    logic        stall_win;
    int issued = 0, got = 0, cyc = 0;
    for (int i = 0; i < 8; i++) begin
      opa[i] = 16'($urandom()); opb[i] = 16'($urandom());
      opc[i] = 1'($urandom_range(0, 1)); ops[i] = 1'($urandom_range(0, 1));
    end
    while (got < 8 && cyc < 60) begin
      stall_win = (cyc >= 6 && cyc <= 9);
      @(posedge clk); #1;
      bus16.out_ready = !stall_win;
      if (issued < 8) begin
        bus16.in_valid = 1'b1; bus16.a = opa[issued]; bus16.b = opb[issued];
        bus16.ci = opc[issued]; bus16.sub = ops[issued];
      end else bus16.in_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus16.in_ready !== !stall_win) begin errors++; $display("FAIL b2b_in_ready cycle %0d: got %b expected %b", cyc, bus16.in_ready, !stall_win); end
      if (bus16.out_valid && !bus16.out_ready) begin
        checks++;
        if (exq.size() == 0 || {bus16.co, bus16.sum} !== exq[0][16:0]) begin
          errors++; $display("FAIL b2b_hold cycle %0d: got %h expected %h", cyc, {bus16.co, bus16.sum}, (exq.size() == 0) ? 17'h0 : exq[0][16:0]);
        end
      end
      if (bus16.in_valid && bus16.in_ready) begin
        exq.push_back(ref_add(64'(bus16.a), 64'(bus16.b), bus16.ci, bus16.sub, 16));
        issued++;
      end
      if (bus16.out_valid && bus16.out_ready) begin
        checks++;
        if (exq.size() == 0) begin
          errors++; $display("FAIL b2b_extra_result: got %h expected none", {bus16.co, bus16.sum});
        end else begin
          e = exq.pop_front();
          if ({bus16.co, bus16.sum} !== e[16:0]) begin
            errors++; $display("FAIL b2b_result_%0d: got %h expected %h", got, {bus16.co, bus16.sum}, e[16:0]);
          end
        end
        got++;
      end
      cyc++;
    end
    bus16.out_ready = 1'b1; bus16.in_valid = 1'b0;
    checks++; if (got != 8 || exq.size() != 0) begin errors++; $display("FAIL b2b_count: got %0d results expected 8", got); end
  endtask

`ifdef KS_ADDER_PIPE_OVF_EN
  task automatic test_ovf();
    logic [15:0] ta [3];
    logic [15:0] tb [3];
    logic [15:0] es [3];
    logic        ts [3];
    logic        eo [3];
    int issued = 0, got = 0, cyc = 0;
    ta = '{16'h7FFF, 16'h8000, 16'h0001};
    tb = '{16'h0001, 16'h0001, 16'h0001};
    ts = '{1'b0, 1'b1, 1'b0};
    es = '{16'h8000, 16'h7FFF, 16'h0002};
    eo = '{1'b1, 1'b1, 1'b0};
    while (got < 3 && cyc < 30) begin
      @(posedge clk); #1;
      if (issued < 3) begin
        bus16.in_valid = 1'b1; bus16.a = ta[issued]; bus16.b = tb[issued];
        bus16.ci = 1'b0; bus16.sub = ts[issued];
      end else bus16.in_valid = 1'b0;
      @(negedge clk);
      if (bus16.in_valid && bus16.in_ready) issued++;
      if (bus16.out_valid && bus16.out_ready) begin
        checks++;
        if (bus16.ovf !== eo[got] || bus16.sum !== es[got]) begin
          errors++; $display("FAIL ovf_%0d: got ovf=%b sum=%h expected ovf=%b sum=%h", got, bus16.ovf, bus16.sum, eo[got], es[got]);
        end
        got++;
      end
      cyc++;
    end
    bus16.in_valid = 1'b0;
    checks++; if (got != 3) begin errors++; $display("FAIL ovf_count: got %0d expected 3", got); end
  endtask
`endif

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus16.in_valid = 1'b1; bus16.a = 16'(16'h0100 + i); bus16.b = 16'h0011; bus16.ci = 1'b0; bus16.sub = 1'b0;
    end
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; bus16.in_valid = 1'b1; bus16.a = 16'hAAAA;
    @(posedge clk); #1;
    rst_n = 1'b1; bus16.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_flags: got out_valid=%b in_ready=%b expected 0/1", bus16.out_valid, bus16.in_ready); end
    checks++; if (bus16.sum !== 16'h0000 || bus16.co !== 1'b0) begin errors++; $display("FAIL rstmid_data: got co=%b sum=%h expected 0/0000", bus16.co, bus16.sum); end
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale cycle %0d: got out_valid=%b expected 0", n, bus16.out_valid); end
    end
    @(posedge clk); #1;
    bus16.in_valid = 1'b1; bus16.a = 16'h0003; bus16.b = 16'h0004; bus16.ci = 1'b0; bus16.sub = 1'b0;
    @(negedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus16.out_valid !== (n == 5)) begin errors++; $display("FAIL rstmid_new cycle %0d: got out_valid=%b expected %b", n, bus16.out_valid, (n == 5)); end
      if (n == 5) begin
        checks++; if (bus16.sum !== 16'h0007 || bus16.co !== 1'b0) begin errors++; $display("FAIL rstmid_new_result: got co=%b sum=%h expected 0/0007", bus16.co, bus16.sum); end
      end
    end
  endtask

  task automatic test_sweep_w5();
    logic [64:0] exq [$];
    int          cyq [$];
    logic [64:0] e;
    int issued = 0, got = 0, cyc = 0, lat;
    bus5.out_ready = 1'b1;
    while (got < 4096 && cyc < 5000) begin
      @(posedge clk); #1;
      if (issued < 4096) begin
        bus5.in_valid = 1'b1; bus5.a = issued[4:0]; bus5.b = issued[9:5];
        bus5.ci = issued[10]; bus5.sub = issued[11];
      end else bus5.in_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus5.in_ready !== 1'b1) begin errors++; $display("FAIL w5_in_ready cycle %0d: got %b expected 1", cyc, bus5.in_ready); end
      if (bus5.in_valid && bus5.in_ready) begin
        exq.push_back(ref_add(64'(bus5.a), 64'(bus5.b), bus5.ci, bus5.sub, 5));
        cyq.push_back(cyc);
        issued++;
      end
      if (bus5.out_valid && bus5.out_ready) begin
        checks++;
        if (exq.size() == 0) begin
          errors++; $display("FAIL w5_extra_result: got %h expected none", {bus5.co, bus5.sum});
        end else begin
          e = exq.pop_front();
          lat = cyc - cyq.pop_front();
          if ({bus5.co, bus5.sum} !== e[5:0]) begin errors++; $display("FAIL w5_result_%0d: got %h expected %h", got, {bus5.co, bus5.sum}, e[5:0]); end
          checks++; if (lat != 4) begin errors++; $display("FAIL w5_latency_%0d: got %0d expected 4", got, lat); end
        end
        got++;
      end
      cyc++;
    end
    bus5.in_valid = 1'b0;
    checks++; if (got != 4096) begin errors++; $display("FAIL w5_count: got %0d expected 4096", got); end
  endtask

  task automatic test_sweep_w64();
    logic [64:0] exq [$];
    int          cyq [$];
    logic [64:0] e;
    int issued = 0, got = 0, cyc = 0, lat;
    bus64.out_ready = 1'b1;
    while (got < 200 && cyc < 400) begin
      @(posedge clk); #1;
      if (issued == 0) begin
        bus64.in_valid = 1'b1; bus64.a = '1; bus64.b = 64'd1; bus64.ci = 1'b0; bus64.sub = 1'b0;
      end else if (issued == 1) begin
        bus64.in_valid = 1'b1; bus64.a = '0; bus64.b = 64'd1; bus64.ci = 1'b0; bus64.sub = 1'b1;
      end else if (issued < 200) begin
        bus64.in_valid = 1'b1; bus64.a = {$urandom(), $urandom()}; bus64.b = {$urandom(), $urandom()};
        bus64.ci = 1'($urandom_range(0, 1)); bus64.sub = 1'($urandom_range(0, 1));
      end else bus64.in_valid = 1'b0;
      @(negedge clk);
      if (bus64.in_valid && bus64.in_ready) begin
        exq.push_back(ref_add(bus64.a, bus64.b, bus64.ci, bus64.sub, 64));
        cyq.push_back(cyc);
        issued++;
      end
      if (bus64.out_valid && bus64.out_ready) begin
        checks++;
        if (got == 0 && (bus64.sum !== 64'd0 || bus64.co !== 1'b1)) begin
          errors++; $display("FAIL w64_wrap: got co=%b sum=%h expected co=1 sum=0", bus64.co, bus64.sum);
        end
        if (exq.size() == 0) begin
          errors++; $display("FAIL w64_extra_result: got %h expected none", {bus64.co, bus64.sum});
        end else begin
          e = exq.pop_front();
          lat = cyc - cyq.pop_front();
          if ({bus64.co, bus64.sum} !== e) begin errors++; $display("FAIL w64_result_%0d: got %h expected %h", got, {bus64.co, bus64.sum}, e); end
          checks++; if (lat != 7) begin errors++; $display("FAIL w64_latency_%0d: got %0d expected 7", got, lat); end
        end
        got++;
      end
      cyc++;
    end
    bus64.in_valid = 1'b0;
    checks++; if (got != 200) begin errors++; $display("FAIL w64_count: got %0d expected 200", got); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.a = '0; bus16.b = '0; bus16.ci = 1'b0; bus16.sub = 1'b0;
    bus5.in_valid  = 1'b0; bus5.out_ready  = 1'b1; bus5.a  = '0; bus5.b  = '0; bus5.ci  = 1'b0; bus5.sub  = 1'b0;
    bus64.in_valid = 1'b0; bus64.out_ready = 1'b1; bus64.a = '0; bus64.b = '0; bus64.ci = 1'b0; bus64.sub = 1'b0;
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
`ifdef KS_ADDER_PIPE_OVF_EN
    test_ovf();
`endif
    test_reset_mid();
    test_sweep_w5();
    test_sweep_w64();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ks_adder_pipe.md
KS_ADDER_PIPE -- requirements
Module: ks_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal range 2..64, non-powers-of-two allowed.
REQ-002 SHALL derive local constant LEVELS = clog2(WIDTH), the number of prefix levels, and LAT = LEVELS+1, the latency in cycles.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous reset, active-low.
REQ-005 SHALL have port in_valid  input  1  operands presented this cycle.
REQ-006 SHALL have port in_ready  output  1  pipeline accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port ci  input  1  carry in.
REQ-010 SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port co  output  1  carry out (not-borrow when sub=1).

Function
REQ-015 SHALL compute {co,sum} = a + b_eff + cin_eff, with b_eff = sub ? ~b : b and cin_eff = ci ^ sub, so sub=1, ci=0 gives a-b.
REQ-016 SHALL fold cin_eff into bit-0 generate/propagate, form per-bit g=a&b_eff and p=a^b_eff, and resolve carries with a Kogge-Stone prefix tree of distance 2^(k-1) at level k.
REQ-017 SHALL register stage 0 (p/g generation) and one register stage after each prefix level; sum = p0 ^ shifted final-level generate, with co = final generate of bit WIDTH-1.
REQ-018 SHALL carry a valid bit per stage; a transfer occurs when in_valid && in_ready; result appears with out_valid exactly LAT cycles after transfer when never stalled.
REQ-019 SHALL define stall = out_valid && !out_ready; in_ready = !stall; during stall all stages, including bubbles, hold their contents.
REQ-020 SHALL advance all stages when not stalled; an empty slot (in_valid=0) propagates as a bubble; bubbles are not collapsed.
REQ-021 SHALL hold sum/co stable while out_valid && !out_ready.
REQ-022 SHALL sustain one result per cycle with out_ready held high; in_ready SHALL then be continuously 1.
REQ-023 SHALL preserve result order; no result SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-024 SHALL accept a new operand in the same cycle the stalled head result is consumed (out_ready=1 releases stall combinationally).
REQ-025 SHALL produce correct carry for WIDTH not a power of two; missing prefix partners at the low end pass through unchanged.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, clear all stage valid bits; out_valid=0, in_ready=1 the following cycle.
REQ-027 SHALL reset sum=0, co=0 (and ovf=0 when present); datapath interior registers need not be reset.
REQ-028 SHALL discard in-flight operations on reset mid-operation; no stale result SHALL emerge afterwards.
REQ-029 SHALL ignore in_valid during reset.

Configuration
REQ-030 SHALL, with macro KS_ADDER_PIPE_OVF_EN defined, add port ovf  output  1  signed overflow = carry into bit WIDTH-1 XOR co, aligned with sum and held under stall.
REQ-031 SHALL, without KS_ADDER_PIPE_OVF_EN, have no ovf port and no associated logic; all other behaviour SHALL be identical.

Verification
REQ-032 SHALL cover WIDTH=16: a=0xFFFF, b=0x0001, ci=0, sub=0 -> sum=0x0000, co=1, out_valid exactly 5 cycles after transfer.
REQ-033 SHALL cover WIDTH=16 subtract: a=0x0005, b=0x0007, ci=0, sub=1 -> sum=0xFFFE, co=0; a=0x0007, b=0x0005 -> sum=0x0002, co=1.
REQ-034 SHALL cover back-to-back transfers of 8 random operands, out_ready low for cycles 6-9 -> in_ready low exactly while stalled, sum/co held, all 8 results in order and matching reference model.
REQ-035 SHALL cover rst_n pulsed low 2 cycles after 3 transfers -> out_valid stays 0 until a new transfer plus 5 cycles; no old result appears.
REQ-036 SHALL cover, with KS_ADDER_PIPE_OVF_EN, WIDTH=16: 0x7FFF+0x0001 -> ovf=1; 0x8000-0x0001 (sub=1) -> ovf=1, sum=0x7FFF; 0x0001+0x0001 -> ovf=0.
REQ-037 SHALL cover WIDTH=5 (LAT=4) and WIDTH=64 (LAT=7) exhaustive/random sweeps of add and subtract against a reference model.
